bram_rd_streamer: RTL
=====================

// Module: bram_rd_streamer
// PURPOSE
//  Read-side companion to the single-clock dual-port block RAM. On a start
//  command it walks a contiguous address range on the RAM read port
//  (enb/addrb/dob, 1-cycle read latency) and emits the words as a
//  valid/ready stream. Back-pressure never loses or duplicates a word.
// PARAMETERS
//  ADDR_W  10  RAM address width (depth = 2**ADDR_W)
//  DATA_W  16  RAM word width
//  LEN_W   11  burst length width (max length 2**ADDR_W)
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       command strobe; accepted only when busy==0
//  base_addr  in   ADDR_W  first RAM address of the burst
//  length     in   LEN_W   number of words to stream
//  abort      in   1       synchronous cancel of the current burst
//  busy       out  1       burst in progress (command not accepted)
//  done       out  1       one-cycle pulse after the last word is accepted
//  enb        out  1       RAM read enable
//  addrb      out  ADDR_W  RAM read address
//  dob        in   DATA_W  RAM read data, valid the cycle after enb
//  m_valid    out  1       stream word valid
//  m_data     out  DATA_W  stream word
//  m_ready    in   1       downstream accepts when m_valid & m_ready
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; busy=0, done=0, enb=0, addrb=0,
//    m_valid=0, m_data=0. Buffer, in-flight flag and counters cleared.
//    Any RAM read in flight is discarded.
//  - FSM: IDLE -> READ on start (latch base_addr and length, busy=1 the
//    next cycle). READ -> DRAIN when the last read is issued. DRAIN -> IDLE
//    when the buffer is empty and no read is in flight. done pulses on the
//    DRAIN->IDLE transition cycle+1, and busy=0 in that same cycle.
//  - length==0: IDLE -> IDLE. busy=1 for one cycle, then done pulses. No
//    enb is issued.
//  - Read issue: enb=1 in a cycle iff state==READ, reads remain, and
//    occ + inflight - pop < 2. occ is buffer occupancy (0..2), inflight
//    is the enb from the previous cycle, and pop is m_valid & m_ready.
//    addrb increments by 1 per issued read and wraps modulo 2**ADDR_W
//    (e.g. 0x3FF -> 0x000).
//  - Capture: if inflight, dob is written into the 2-entry FIFO that cycle.
//    m_valid/m_data come from the FIFO head, so a word is never dropped.
//  - Latency: start at cycle T -> first enb at T+1 -> first m_valid at T+3.
//    With m_ready held at 1 the stream sustains 1 word/cycle.
//  - m_data is stable while m_valid=1 and m_ready=0.
//  - start while busy=1 is ignored with no side effect.
//  - abort (any state other than IDLE): enb=0 that cycle, FIFO flushed,
//    in-flight data discarded, m_valid=0 next cycle, state IDLE next cycle.
//    No done pulse. abort has priority over start; abort in IDLE is a no-op.
//  - abort and start in the same IDLE cycle: start is ignored.
// STRUCTURE
//  - Shared package bram_rd_pkg:
//    - state encoding IDLE/READ/DRAIN as localparams
//    - default ADDR_W/DATA_W/LEN_W constants
//  - One sub-module, bram_rd_skid: a 2-entry FIFO with push/pop/flush and
//    occ output, parameterised by DATA_W.
//  - Top level holds the FSM, address/remaining counters and issue logic.
// TESTING
//  1 start base=0x010 len=4, m_ready=1, RAM[a]=a -> enb T+1..T+4,
//    m_data 0x10,0x11,0x12,0x13 on T+3..T+6, done on T+7, busy=0 on T+7.
//  2 same burst, m_ready toggled 1,0,0,1,0,1.. -> exactly 4 words in order,
//    none repeated. enb never raises occ+inflight above 2.
//  3 base=0x3FE len=4 -> addrb 0x3FE,0x3FF,0x000,0x001, data in that order.
//  4 len=0 -> enb never 1, m_valid never 1, done pulses 2 cycles after start.
//  5 abort mid-burst with 1 word buffered and 1 read in flight -> m_valid=0
//    next cycle, IDLE, no done. A new start then streams the correct data.
//  6 rst_n low mid-burst with m_ready=0 -> all outputs 0 immediately.
//    Extra start pulses while busy=1 do not alter the burst.

Source files
------------

// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared constants and FSM state type for the BRAM read streamer.
package bram_rd_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 11;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        DRAIN = ST_DRAIN
    } state_t;
endpackage

// File: rtl/bram_rd_streamer_if.sv
// bram_rd_streamer_if: valid/ready output stream of the BRAM read streamer.
interface bram_rd_streamer_if
    import bram_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/bram_rd_skid.sv
// bram_rd_skid: 2-entry FIFO catching RAM read data so back-pressure never drops a word.
module bram_rd_skid
    import bram_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [1:0]        o_occ,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_flush) begin
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (i_pop)
                r_rd <= ~r_rd;
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_occ   = r_occ;
    assign o_valid = r_occ != 2'd0;
    assign o_data  = r_mem[r_rd];
endmodule

// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: walks a contiguous BRAM address range and emits the words
// as a valid/ready stream, throttling reads so at most two words are outstanding.
module bram_rd_streamer
    import bram_rd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dob,
    bram_rd_streamer_if.master m
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;
    logic              r_zlen;
    logic [1:0]        w_occ;
    logic              w_pop;
    logic              w_room;
    logic              w_issue;
    logic              w_empty;
    logic              w_accept;
    logic              w_abort;

    assign w_abort  = abort && r_state != IDLE;
    assign w_pop    = m.m_valid && m.m_ready;
    // a read is only issued if its word is guaranteed a FIFO slot
    assign w_room   = ({1'b0, w_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
    assign w_issue  = r_state == READ && r_rem != '0 && w_room && !abort;
    assign w_empty  = !r_inflight && w_occ == {1'b0, w_pop};
    assign w_accept = r_state == IDLE && !r_busy && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_zlen     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_rem  <= r_rem - LEN_W'(1);
                end
                if (r_state == IDLE && r_zlen) begin
                    r_zlen <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else if (w_accept) begin
                    r_addr  <= base_addr;
                    r_rem   <= length;
                    r_busy  <= 1'b1;
                    r_zlen  <= length == '0;
                    r_state <= length == '0 ? IDLE : READ;
                end else if (r_state == READ && w_issue && r_rem == LEN_W'(1)) begin
                    r_state <= DRAIN;
                end else if (r_state == DRAIN && w_empty) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    bram_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (dob),
        .i_pop   (w_pop),
        .i_flush (w_abort),
        .o_occ   (w_occ),
        .o_valid (m.m_valid),
        .o_data  (m.m_data)
    );

    assign busy  = r_busy;
    assign done  = r_done;
    assign enb   = w_issue;
    assign addrb = r_addr;
endmodule
